// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle adder/subtractor that processes WIDTH-bit operands
// CHUNK bits per clock, least significant chunk first, with a registered carry
// between chunks.
//
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset
//   start     - request a new operation (accepted in IDLE and FIN, ignored in RUN)
//   sub       - 0 = add, 1 = subtract (sampled with start)
//   a, b      - operands (sampled with start)
//   cin       - carry-in (add) / borrow-in (subtract), sampled with start
//   busy      - high while chunks are being processed
//   done      - one-cycle pulse when sum/cout/ovf have just updated
//   sum       - last completed result
//   cout      - carry out of the MSB (subtract: 1 = no borrow)
//   ovf       - two's-complement overflow of the last result
//   dbg_state - current FSM state (0 = IDLE, 1 = RUN, 2 = FIN)
//
// Handshake: start is a request sampled at a rising edge; it is taken only when
// busy=0. The result is valid for exactly the cycle in which done=1 and then
// held on sum/cout/ovf until the next completion or reset.
module chunked_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [1:0]       dbg_state
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_psum;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic [CHUNK:0]   w_chunk;
    logic             w_c_msb;
    logic [WIDTH-1:0] w_psum_next;
    logic             w_last;
    logic             w_accept;

    // Chunk datapath. The carry into the chunk's top bit is recovered from
    // sum_bit = a ^ b ^ carry_in, which works for any CHUNK including 1
    // (where it reduces to the carry register itself).
    always_comb begin
        w_chunk     = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]}
                    + {{CHUNK{1'b0}}, r_carry};
        w_c_msb     = w_chunk[CHUNK-1] ^ r_a[CHUNK-1] ^ r_b[CHUNK-1];
        w_psum_next = r_psum >> CHUNK;
        w_psum_next[WIDTH-1 -: CHUNK] = w_chunk[CHUNK-1:0];
    end

    assign w_last   = (r_cnt == LAST);
    assign w_accept = start && (r_state != S_RUN);

    // Next-state and output decode
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) w_next = S_FIN;
            end
            S_FIN: begin
                done   = 1'b1;
                w_next = start ? S_RUN : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_psum  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            // Subtract is a + ~b + ~cin: invert B and the incoming carry.
            r_a     <= a;
            r_b     <= b ^ {WIDTH{sub}};
            r_carry <= cin ^ sub;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_a     <= r_a >> CHUNK;
            r_b     <= r_b >> CHUNK;
            r_carry <= w_chunk[CHUNK];
            r_cnt   <= r_cnt + CNT_W'(1);
            r_psum  <= w_psum_next;
            if (w_last) begin
                r_sum  <= w_psum_next;
                r_cout <= w_chunk[CHUNK];
                r_ovf  <= w_c_msb ^ w_chunk[CHUNK];
            end
        end
    end

    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign dbg_state = r_state;

endmodule
